add_subtract: RTL and testbench

Registered 8-bit unsigned adder/subtractor with a three-digit packed-BCD result, carry and sign flags. It sits between operand sources (switches or registers) and a BCD display driver. Each enabled clock edge computes a+b or |a−b| and converts it to BCD. Outputs hold between operations.

---
 rtl/add_subtract_pkg.sv | 15 +
 rtl/add_subtract_if.sv | 29 ++
 rtl/add_subtract_bin2bcd9.sv | 39 +++
 rtl/add_subtract.sv | 81 ++++++++
 tb/tb_add_subtract.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/add_subtract_pkg.sv
// add_subtract_pkg: shared constants and types for the add_subtract block.
//   OP_ADD / OP_SUB : encodings of the add_sub operation select
//   result_t        : registered output bundle (BCD magnitude, carry, sign)
package add_subtract_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [11:0] bcd;
        logic        cout;
        logic        sign;
    } result_t;

endpackage : add_subtract_pkg

// File: rtl/add_subtract_if.sv
// add_subtract_if: operand/result bundle for the add_subtract block.
//   a, b       : 8-bit unsigned operands
//   add_sub    : 0 = add, 1 = subtract
//   enable     : active-low, 0 = compute on this edge, 1 = hold
//   bcd_result : 3-digit packed BCD magnitude
//   cout       : carry out of an addition
//   sign_flag  : subtraction result was negative
// master = operand source / result consumer, slave = the arithmetic block.
interface add_subtract_if;

    logic [7:0]  a;
    logic [7:0]  b;
    logic        add_sub;
    logic        enable;
    logic [11:0] bcd_result;
    logic        cout;
    logic        sign_flag;

    modport master (
        output a, b, add_sub, enable,
        input  bcd_result, cout, sign_flag
    );

    modport slave (
        input  a, b, add_sub, enable,
        output bcd_result, cout, sign_flag
    );

endinterface : add_subtract_if

// File: rtl/add_subtract_bin2bcd9.sv
// bin2bcd9: combinational 9-bit binary to 3-digit packed BCD converter
// using shift-add-3 (double dabble).
//   bin : binary input, 0..511
//   bcd : packed BCD, [11:8] hundreds, [7:4] tens, [3:0] ones
module bin2bcd9 (
    input  logic [8:0]  bin,
    output logic [11:0] bcd
);

    // 21-bit scratch: upper 12 bits hold the BCD digits, lower 9 the binary.
    logic [20:0] shift_s;

    // Double dabble: before each of the 9 shifts, bias any digit >= 5 by 3 so
    // the shift carries correctly into the next decimal digit.
    always_comb begin
        shift_s = {12'd0, bin};
        for (int i = 0; i < 9; i++) begin
            if (shift_s[12:9] >= 4'd5) begin
                shift_s[12:9] = shift_s[12:9] + 4'd3;
            end else begin
                shift_s[12:9] = shift_s[12:9];
            end
            if (shift_s[16:13] >= 4'd5) begin
                shift_s[16:13] = shift_s[16:13] + 4'd3;
            end else begin
                shift_s[16:13] = shift_s[16:13];
            end
            if (shift_s[20:17] >= 4'd5) begin
                shift_s[20:17] = shift_s[20:17] + 4'd3;
            end else begin
                shift_s[20:17] = shift_s[20:17];
            end
            shift_s = {shift_s[19:0], 1'b0};
        end
    end

    assign bcd = shift_s[20:9];

endmodule : bin2bcd9

// File: rtl/add_subtract.sv
// add_subtract: registered 8-bit unsigned adder/subtractor with packed-BCD
// magnitude output, carry and sign flags. One-cycle latency; outputs hold
// while enable is high.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, takes priority over enable
//   bus : add_subtract_if slave (operands, op select, enable, results)
module add_subtract
    import add_subtract_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    add_subtract_if.slave      bus
);

    logic        a_ge_b_s;
    logic [8:0]  sum_s;
    logic [7:0]  diff_s;
    logic [8:0]  bin_s;
    logic [11:0] bcd_s;
    result_t     next_s;
    result_t     result_r;

    // Comparator and both arithmetic paths; the smaller operand is always
    // subtracted from the larger so the magnitude never underflows.
    always_comb begin
        a_ge_b_s = (bus.a >= bus.b);
        sum_s    = {1'b0, bus.a} + {1'b0, bus.b};
        if (a_ge_b_s) begin
            diff_s = bus.a - bus.b;
        end else begin
            diff_s = bus.b - bus.a;
        end
    end

    // Operation mux: selects the value to convert and the flags for it.
    always_comb begin
        bin_s       = sum_s;
        next_s.cout = 1'b0;
        next_s.sign = 1'b0;
        case (bus.add_sub)
            OP_ADD: begin
                bin_s       = sum_s;
                next_s.cout = sum_s[8];
                next_s.sign = 1'b0;
            end
            OP_SUB: begin
                bin_s       = {1'b0, diff_s};
                next_s.cout = 1'b0;
                // a == b gives sign 0, so negative zero cannot appear.
                next_s.sign = ~a_ge_b_s;
            end
            default: begin
                bin_s       = sum_s;
                next_s.cout = sum_s[8];
                next_s.sign = 1'b0;
            end
        endcase
        next_s.bcd = bcd_s;
    end

    bin2bcd9 u_bin2bcd9 (
        .bin (bin_s),
        .bcd (bcd_s)
    );

    // Output register: reset clears, enable low loads, enable high holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= '{bcd: 12'h000, cout: 1'b0, sign: 1'b0};
        end else if (!bus.enable) begin
            result_r <= next_s;
        end else begin
            result_r <= result_r;
        end
    end

    assign bus.bcd_result = result_r.bcd;
    assign bus.cout       = result_r.cout;
    assign bus.sign_flag  = result_r.sign;

endmodule : add_subtract

// File: tb/tb_add_subtract.sv
// tb_add_subtract: directed, table-driven self-checking bench for add_subtract.
module tb_add_subtract;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    add_subtract_if bus ();

    add_subtract dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        op;
        logic [11:0] exp_bcd;
        logic        exp_cout;
        logic        exp_sign;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [11:0] bcd,
                         input logic c, input logic s);
        checks++;
        if (bus.bcd_result !== bcd || bus.cout !== c || bus.sign_flag !== s) begin
            errors++;
            $display("FAIL %s: got bcd=%h cout=%b sign=%b, expected bcd=%h cout=%b sign=%b",
                     name, bus.bcd_result, bus.cout, bus.sign_flag, bcd, c, s);
        end
    endtask

    // Drive inputs on the falling edge, away from the sampling edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic op, input logic en);
        @(negedge clk);
        bus.a       = a;
        bus.b       = b;
        bus.add_sub = op;
        bus.enable  = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{8'd1,   8'd2,   1'b0, 12'h003, 1'b0, 1'b0};
        vecs[1]  = '{8'd100, 8'd27,  1'b0, 12'h127, 1'b0, 1'b0};
        vecs[2]  = '{8'd255, 8'd255, 1'b0, 12'h510, 1'b1, 1'b0};
        vecs[3]  = '{8'd200, 8'd56,  1'b0, 12'h256, 1'b1, 1'b0};
        vecs[4]  = '{8'd128, 8'd127, 1'b0, 12'h255, 1'b0, 1'b0};
        vecs[5]  = '{8'd1,   8'd2,   1'b1, 12'h001, 1'b0, 1'b1};
        vecs[6]  = '{8'd0,   8'd255, 1'b1, 12'h255, 1'b0, 1'b1};
        vecs[7]  = '{8'd2,   8'd1,   1'b1, 12'h001, 1'b0, 1'b0};
        vecs[8]  = '{8'd150, 8'd75,  1'b1, 12'h075, 1'b0, 1'b0};
        vecs[9]  = '{8'd77,  8'd77,  1'b1, 12'h000, 1'b0, 1'b0};
        vecs[10] = '{8'd255, 8'd0,   1'b1, 12'h255, 1'b0, 1'b0};
        vecs[11] = '{8'd0,   8'd0,   1'b0, 12'h000, 1'b0, 1'b0};
        vecs[12] = '{8'd99,  8'd0,   1'b0, 12'h099, 1'b0, 1'b0};
        vecs[13] = '{8'd250, 8'd9,   1'b0, 12'h259, 1'b1, 1'b0};
        vecs[14] = '{8'd9,   8'd250, 1'b1, 12'h241, 1'b0, 1'b1};

        // Reset with enable low and 5+5 presented.
        rst         = 1'b1;
        bus.a       = 8'd5;
        bus.b       = 8'd5;
        bus.add_sub = 1'b0;
        bus.enable  = 1'b0;
        tick();
        tick();
        check("reset", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("after_reset_5p5", 12'h010, 1'b0, 1'b0);

        // Back-to-back table vectors, one result per edge.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp_bcd,
                  vecs[i].exp_cout, vecs[i].exp_sign);
        end

        // Hold: enable high, inputs changing, outputs frozen at vec14 result.
        drive(8'd255, 8'd255, 1'b0, 1'b1);
        tick();
        check("hold1", 12'h241, 1'b0, 1'b1);
        drive(8'd3, 8'd1, 1'b1, 1'b1);
        tick();
        check("hold2", 12'h241, 1'b0, 1'b1);
        drive(8'd200, 8'd100, 1'b0, 1'b1);
        tick();
        check("hold3", 12'h241, 1'b0, 1'b1);

        // Re-enable: nothing changes before the edge, new result after it.
        drive(8'd10, 8'd3, 1'b1, 1'b0);
        #1;
        check("reenable_pre_edge", 12'h241, 1'b0, 1'b1);
        tick();
        check("reenable", 12'h007, 1'b0, 1'b0);

        // Reset mid-stream clears on that edge, even with a carry-producing op.
        drive(8'd255, 8'd255, 1'b0, 1'b0);
        tick();
        check("pre_mid_reset", 12'h510, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("mid_reset", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_mid_reset", 12'h510, 1'b1, 1'b0);

        // Reset beats a held (enable high) state.
        @(negedge clk);
        bus.enable = 1'b1;
        rst        = 1'b1;
        tick();
        check("reset_over_hold", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("hold_after_reset", 12'h000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_add_subtract
